twenty_bit_divider: RTL and testbench



---
 rtl/divider_pkg.sv | 22 ++
 rtl/divider_step.sv | 22 ++
 rtl/twenty_bit_divider.sv | 169 ++++++++++++++++
 tb/tb_twenty_bit_divider.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// Shared widths, FSM state type and error-result helper for the 28/8 restoring divider.
package divider_pkg;

    localparam int unsigned DIVIDEND_W = 28;
    localparam int unsigned DIVISOR_W  = 8;
    localparam int unsigned QUOTIENT_W = 20;
    localparam int unsigned COUNT_W    = 5;

    localparam logic [QUOTIENT_W-1:0] QUOTIENT_SAT = 20'hFFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Quotient reported for a zero divisor or an overflowing quotient.
    function automatic logic [QUOTIENT_W-1:0] err_quotient(input logic sat_en);
        return sat_en ? QUOTIENT_SAT : '0;
    endfunction

endpackage

// File: rtl/divider_step.sv
// One restoring-division iteration: shift in a dividend bit, subtract divisor if it fits.
module divider_step
    import divider_pkg::*;
(
    input  logic [DIVISOR_W-1:0] i_rem,
    input  logic                 i_bit,
    input  logic [DIVISOR_W-1:0] i_divisor,
    output logic [DIVISOR_W-1:0] o_rem,
    output logic                 o_qbit
);

    logic [DIVISOR_W:0] w_trial;
    logic [DIVISOR_W:0] w_div_ext;

    assign w_trial   = {i_rem, i_bit};
    assign w_div_ext = {1'b0, i_divisor};

    // The 9-bit trial keeps the carry so a partial remainder up to 2*divisor-1 compares correctly.
    assign o_qbit = (w_trial >= w_div_ext);
    assign o_rem  = o_qbit ? DIVISOR_W'(w_trial - w_div_ext) : w_trial[DIVISOR_W-1:0];

endmodule

// File: rtl/twenty_bit_divider.sv
// Sequential restoring divider: 28-bit / 8-bit -> 20-bit quotient + 8-bit remainder,
// one quotient bit per clock, start/done handshake.
// Build option: define TWENTY_BIT_DIVIDER_SAT_EN to return an all-ones quotient on error.
module twenty_bit_divider
    import divider_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [QUOTIENT_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  overflow
);

`ifdef TWENTY_BIT_DIVIDER_SAT_EN
    localparam logic SAT_EN = 1'b1;
`else
    localparam logic SAT_EN = 1'b0;
`endif
    localparam logic [QUOTIENT_W-1:0] ERR_QUOT   = err_quotient(SAT_EN);
    localparam logic [COUNT_W-1:0]    LAST_COUNT = COUNT_W'(QUOTIENT_W - 1);

    state_t                r_state;
    logic [COUNT_W-1:0]    r_count;
    logic [DIVISOR_W-1:0]  r_rem;
    logic [QUOTIENT_W-1:0] r_shift;
    logic [DIVISOR_W-1:0]  r_divisor;
    logic                  r_busy;
    logic                  r_done;
    logic [QUOTIENT_W-1:0] r_quotient;
    logic [DIVISOR_W-1:0]  r_remainder;
    logic                  r_div_by_zero;
    logic                  r_overflow;

    state_t                w_state_nxt;
    logic [COUNT_W-1:0]    w_count_nxt;
    logic [DIVISOR_W-1:0]  w_rem_nxt;
    logic [QUOTIENT_W-1:0] w_shift_nxt;
    logic [DIVISOR_W-1:0]  w_divisor_nxt;
    logic                  w_busy_nxt;
    logic                  w_done_nxt;
    logic [QUOTIENT_W-1:0] w_quotient_nxt;
    logic [DIVISOR_W-1:0]  w_remainder_nxt;
    logic                  w_div_by_zero_nxt;
    logic                  w_overflow_nxt;

    logic [DIVISOR_W-1:0]  w_dividend_hi;
    logic [QUOTIENT_W-1:0] w_dividend_lo;
    logic [DIVISOR_W-1:0]  w_step_rem;
    logic                  w_step_qbit;

    assign w_dividend_hi = dividend[DIVIDEND_W-1:QUOTIENT_W];
    assign w_dividend_lo = dividend[QUOTIENT_W-1:0];

    // Single shared iteration datapath; the dividend bits leave the shift register MSB-first
    // while quotient bits enter at the LSB, so the register ends up holding the quotient.
    divider_step u_step (
        .i_rem     (r_rem),
        .i_bit     (r_shift[QUOTIENT_W-1]),
        .i_divisor (r_divisor),
        .o_rem     (w_step_rem),
        .o_qbit    (w_step_qbit)
    );

    // Next-state and next-output logic for the IDLE -> DIV -> DONE sequence.
    always_comb begin
        w_state_nxt       = r_state;
        w_count_nxt       = r_count;
        w_rem_nxt         = r_rem;
        w_shift_nxt       = r_shift;
        w_divisor_nxt     = r_divisor;
        w_busy_nxt        = r_busy;
        w_done_nxt        = 1'b0;
        w_quotient_nxt    = r_quotient;
        w_remainder_nxt   = r_remainder;
        w_div_by_zero_nxt = r_div_by_zero;
        w_overflow_nxt    = r_overflow;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_busy_nxt        = 1'b1;
                    w_divisor_nxt     = divisor;
                    w_div_by_zero_nxt = 1'b0;
                    w_overflow_nxt    = 1'b0;
                    if (divisor == '0) begin
                        w_div_by_zero_nxt = 1'b1;
                        w_quotient_nxt    = ERR_QUOT;
                        w_remainder_nxt   = '0;
                        w_state_nxt       = DONE;
                    end else if (w_dividend_hi >= divisor) begin
                        // Upper bits already hold a full divisor: quotient needs more than 20 bits.
                        w_overflow_nxt    = 1'b1;
                        w_quotient_nxt    = ERR_QUOT;
                        w_remainder_nxt   = '0;
                        w_state_nxt       = DONE;
                    end else begin
                        w_rem_nxt   = w_dividend_hi;
                        w_shift_nxt = w_dividend_lo;
                        w_count_nxt = '0;
                        w_state_nxt = DIV;
                    end
                end
            end
            DIV: begin
                w_rem_nxt   = w_step_rem;
                w_shift_nxt = {r_shift[QUOTIENT_W-2:0], w_step_qbit};
                w_count_nxt = r_count + COUNT_W'(1);
                if (r_count == LAST_COUNT) begin
                    w_busy_nxt      = 1'b0;
                    w_quotient_nxt  = {r_shift[QUOTIENT_W-2:0], w_step_qbit};
                    w_remainder_nxt = w_step_rem;
                    w_state_nxt     = DONE;
                end
            end
            DONE: begin
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_count       <= '0;
            r_rem         <= '0;
            r_shift       <= '0;
            r_divisor     <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_count       <= w_count_nxt;
            r_rem         <= w_rem_nxt;
            r_shift       <= w_shift_nxt;
            r_divisor     <= w_divisor_nxt;
            r_busy        <= w_busy_nxt;
            r_done        <= w_done_nxt;
            r_quotient    <= w_quotient_nxt;
            r_remainder   <= w_remainder_nxt;
            r_div_by_zero <= w_div_by_zero_nxt;
            r_overflow    <= w_overflow_nxt;
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_twenty_bit_divider.sv
// Bench for twenty_bit_divider: arithmetic reference model checked every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_twenty_bit_divider;

`ifdef TWENTY_BIT_DIVIDER_SAT_EN
    localparam logic [19:0] ERR_Q = 20'hFFFFF;
`else
    localparam logic [19:0] ERR_Q = 20'h00000;
`endif

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [27:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [19:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;
    logic        overflow;

    int n_vec  = 0;
    int n_miss = 0;

    twenty_bit_divider dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: results from plain division, timing from accept-edge age.
    logic        m_active   = 1'b0;
    int          m_age      = 0;
    int          m_busy_len = 0;
    int          m_done_age = 0;
    logic [19:0] m_q        = '0;
    logic [19:0] m_pq       = '0;
    logic [7:0]  m_r        = '0;
    logic [7:0]  m_pr       = '0;
    logic        m_dbz      = 1'b0;
    logic        m_ovf      = 1'b0;
    longint      ma;
    longint      mb;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_active = 1'b0; m_age = 0; m_q = '0; m_r = '0; m_dbz = 1'b0; m_ovf = 1'b0;
        end else if (start && (!m_active || m_age >= m_done_age)) begin
            ma = longint'(dividend);
            mb = longint'(divisor);
            m_active = 1'b1; m_age = 0; m_dbz = 1'b0; m_ovf = 1'b0;
            if (mb == 0) begin
                m_dbz = 1'b1; m_q = ERR_Q; m_r = '0; m_busy_len = 1; m_done_age = 1;
            end else if (ma / mb >= 64'd1048576) begin
                m_ovf = 1'b1; m_q = ERR_Q; m_r = '0; m_busy_len = 1; m_done_age = 1;
            end else begin
                m_pq = 20'(ma / mb); m_pr = 8'(ma % mb); m_busy_len = 20; m_done_age = 21;
            end
        end else if (m_active && m_age <= m_done_age) begin
            m_age++;
            if (m_done_age == 21 && m_age == 20) begin
                m_q = m_pq;
                m_r = m_pr;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("busy",        32'(busy),        32'(m_active && m_age < m_busy_len));
        chk("done",        32'(done),        32'(m_active && m_age == m_done_age));
        chk("quotient",    32'(quotient),    32'(m_q));
        chk("remainder",   32'(remainder),   32'(m_r));
        chk("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
        chk("overflow",    32'(overflow),    32'(m_ovf));
    end

    // Waits (bounded) for done; lat counts negedges after the accept edge's first negedge.
    task automatic wait_done(output bit seen, output int lat);
        seen = 1'b0;
        lat  = 0;
        while (!seen && lat < 60) begin
            if (done) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [27:0] a, input logic [7:0] b,
                          input logic [19:0] eq, input logic [7:0] er,
                          input logic edz, input logic eov, input int elat);
        bit seen;
        int lat;
        @(negedge clk);
        dividend = a; divisor = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(seen, lat);
        chk({name, " done seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({name, " latency"},   32'(lat),         32'(elat));
            chk({name, " quotient"},  32'(quotient),    32'(eq));
            chk({name, " remainder"}, 32'(remainder),   32'(er));
            chk({name, " dbz"},       32'(div_by_zero), 32'(edz));
            chk({name, " ovf"},       32'(overflow),    32'(eov));
        end
    endtask

    initial begin
        bit          seen;
        int          lat;
        logic [19:0] ra;
        logic [7:0]  rb;

        reset_n = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy",     32'(busy),     32'd0);
        chk("reset quotient", 32'(quotient), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        run_op("1000000/200",  28'd1000000,   8'd200, 20'd5000,    8'd0,   1'b0, 1'b0, 21);
        run_op("max quotient", 28'd267386879, 8'd255, 20'hFFFFF,   8'd254, 1'b0, 1'b0, 21);
        run_op("overflow",     28'hFFFFFFF,   8'd255, ERR_Q,       8'd0,   1'b0, 1'b1, 1);
        run_op("div by zero",  28'd1234,      8'd0,   ERR_Q,       8'd0,   1'b1, 1'b0, 1);
        run_op("after error",  28'd1000,      8'd3,   20'd333,     8'd1,   1'b0, 1'b0, 21);

        // Start pulse while busy must be ignored.
        @(negedge clk);
        dividend = 28'd500; divisor = 8'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        dividend = 28'd9; divisor = 8'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(seen, lat);
        chk("ignored start done seen", 32'(seen),      32'd1);
        chk("ignored start latency",   32'(lat),       32'd16);
        chk("ignored start quotient",  32'(quotient),  32'd71);
        chk("ignored start remainder", 32'(remainder), 32'd3);

        // Reset in the middle of an operation.
        @(negedge clk);
        dividend = 28'd1000000; divisor = 8'd200; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        chk("midreset busy",      32'(busy),      32'd0);
        chk("midreset done",      32'(done),      32'd0);
        chk("midreset quotient",  32'(quotient),  32'd0);
        chk("midreset remainder", 32'(remainder), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        run_op("255/16", 28'd255, 8'd16, 20'd15, 8'd15, 1'b0, 1'b0, 21);

        // Product round trip: (a*b)/b == a with zero remainder.
        for (int i = 0; i < 300; i++) begin
            ra = 20'($urandom_range(0, 20'hFFFFF));
            rb = 8'($urandom_range(1, 255));
            run_op("round trip", 28'(ra * rb), rb, ra, 8'd0, 1'b0, 1'b0, 21);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
